// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Multi-cycle fetch/execute control FSM driving memory_system.
//               Optional macro SINGLE_STEP_EN adds a `step` input that gates F0.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [4:0] instruction,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    output logic       ir_sclr,
    output logic       mar_sclr,
    output logic       enaf,
    output logic       bank_wr_en,
    output logic       ir_en,
    output logic       mar_en,
    output logic       wr_rdn,
    output logic       mdr_alu_n,
    output logic       mdr_en,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic [2:0] busB_addr,
    output logic [2:0] busC_addr,
    output logic       instr_done,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state
);

    localparam logic [2:0] C_ALU_SLL   = 3'b000;
    localparam logic [2:0] C_ALU_INC   = 3'b110;
    localparam logic [2:0] C_ALU_PASSB = 3'b111;
    localparam logic [2:0] C_PC_ADDR   = 3'b000;
    localparam logic [2:0] C_DPTR_ADDR = 3'b001;
    localparam logic [2:0] C_A_ADDR    = 3'b010;
    localparam logic [2:0] C_MDR_ADDR  = 3'b100;
    localparam logic [2:0] C_ACC_ADDR  = 3'b111;

    typedef enum logic [3:0] {
        S_CLR  = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_F3   = 4'd4,
        S_E0   = 4'd5,
        S_E1   = 4'd6,
        S_E2   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t r_state;
    state_t w_next;

    // N and P are part of the flag interface but no opcode branches on them.
    logic w_unused_flags;
    assign w_unused_flags = N ^ P;

    assign state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_CLR;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        ir_sclr    = 1'b0;
        mar_sclr   = 1'b0;
        enaf       = 1'b0;
        bank_wr_en = 1'b0;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        wr_rdn     = 1'b0;
        mdr_alu_n  = 1'b0;
        mdr_en     = 1'b0;
        selop      = C_ALU_PASSB;
        shamt      = 2'b00;
        busB_addr  = 3'b000;
        busC_addr  = 3'b000;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;

        case (r_state)
            S_CLR: begin
                ir_sclr  = 1'b1;
                mar_sclr = 1'b1;
                w_next   = S_F0;
            end
            S_F0: begin
`ifdef SINGLE_STEP_EN
                if (step) begin
                    busB_addr = C_PC_ADDR;
                    mar_en    = 1'b1;
                    w_next    = S_F1;
                end
`else
                busB_addr = C_PC_ADDR;
                mar_en    = 1'b1;
                w_next    = S_F1;
`endif
            end
            S_F1: begin
                mdr_en    = 1'b1;
                mdr_alu_n = 1'b1;
                w_next    = S_F2;
            end
            S_F2: begin
                ir_en  = 1'b1;
                w_next = S_F3;
            end
            S_F3: begin
                busB_addr  = C_PC_ADDR;
                busC_addr  = C_PC_ADDR;
                selop      = C_ALU_INC;
                bank_wr_en = 1'b1;
                w_next     = S_E0;
            end
            S_E0: begin
                instr_done = 1'b1;
                w_next     = S_F0;
                casez (instruction)
                    5'b000??: ;
                    5'b001??: begin
                        busB_addr  = C_ACC_ADDR;
                        busC_addr  = C_ACC_ADDR;
                        selop      = C_ALU_SLL;
                        shamt      = instruction[1:0];
                        bank_wr_en = 1'b1;
                        enaf       = 1'b1;
                    end
                    5'b01???: begin
                        busB_addr  = C_A_ADDR;
                        busC_addr  = C_ACC_ADDR;
                        selop      = instruction[2:0];
                        bank_wr_en = 1'b1;
                        enaf       = 1'b1;
                    end
                    5'b1000?: begin
                        busB_addr  = C_DPTR_ADDR;
                        mar_en     = 1'b1;
                        instr_done = 1'b0;
                        w_next     = S_E1;
                    end
                    5'b1001?: begin
                        // bit 0 selects carry (JPC) versus zero (JPZ)
                        if (instruction[0] ? C : Z) begin
                            busB_addr  = C_DPTR_ADDR;
                            busC_addr  = C_PC_ADDR;
                            bank_wr_en = 1'b1;
                        end
                    end
                    5'b11111: w_next = S_HALT;
                    default:  illegal = 1'b1;
                endcase
            end
            S_E1: begin
                mdr_en = 1'b1;
                if (instruction[0]) busB_addr = C_ACC_ADDR;
                else                mdr_alu_n = 1'b1;
                w_next = S_E2;
            end
            S_E2: begin
                if (instruction[0]) begin
                    wr_rdn = 1'b1;
                end else begin
                    busB_addr  = C_MDR_ADDR;
                    busC_addr  = C_ACC_ADDR;
                    bank_wr_en = 1'b1;
                end
                instr_done = 1'b1;
                w_next     = S_F0;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_CLR;
        endcase
    end

endmodule
`default_nettype wire
